// File: rtl/scp_079_multistage_if.sv
// Bus for the multistage intrusion controller.
// Carries the green/yellow/red requests in and the state, level, progress flags,
// dwell timer, cheat flag and retry count out.
// The DUT uses the slave modport; the driver uses the master modport.
interface scp_079_multistage_if #(
   parameter int STAGES = 2,
   parameter int TW     = 6
);
   logic              green;
   logic              yellow;
   logic              red;
   logic [2:0]        state;
   logic [3:0]        level;
   logic [STAGES:0]   a;
   logic [TW-1:0]     timer;
   logic              cheat_out;
   logic [3:0]        retries;

   modport master (
      output green, yellow, red,
      input  state, level, a, timer, cheat_out, retries
   );

   modport slave (
      input  green, yellow, red,
      output state, level, a, timer, cheat_out, retries
   );
endinterface

// File: rtl/scp_079_multistage.sv
// Multistage attack controller: LAYLOW -> ATTACK levels -> CONNECT, with a
// CHEAT penalty dwell that ends in LAYLOW or FAIL.
// Ports: clock, reset (async, active high), bus (slave):
//   in  green/yellow/red, out state/level/a/timer/cheat_out/retries.
// Optional: define SCP_079_RETRY_EN to let FAIL recover to LAYLOW.
module scp_079_multistage #(
   parameter int STAGES   = 2,
   parameter int TW       = 6,
   parameter int LAYLOW_T = 20,
   parameter int ATTACK_T = 10,
   parameter int CHEAT_T  = 15
) (
   input logic                clock,
   input logic                reset,
   scp_079_multistage_if.slave bus
);

   typedef enum logic [2:0] {
      S_LAYLOW  = 3'b000,
      S_CHEAT   = 3'b001,
      S_ATTACK  = 3'b010,
      S_FAIL    = 3'b100,
      S_CONNECT = 3'b101
   } state_t;

   localparam logic [STAGES:0] A_ONE  = 1;
   localparam logic [TW-1:0]   LAY_TH = TW'(LAYLOW_T);
   localparam logic [TW-1:0]   ATK_TH = TW'(ATTACK_T);
   localparam logic [TW-1:0]   CHT_TH = TW'(CHEAT_T);
   localparam logic [3:0]      TOP    = 4'(STAGES);

   state_t          state_q, state_n;
   logic [3:0]      level_q, level_n;
   logic [STAGES:0] a_q, a_n;
   logic [TW-1:0]   timer_q;
   logic            cheat_q, cheat_n;
   logic [3:0]      retries_q, retries_n;
   logic            step;

   // Any state or level change restarts the dwell count at 1.
   assign step = (state_n != state_q) || (level_n != level_q);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_LAYLOW;
         level_q   <= 4'd0;
         a_q       <= '0;
         timer_q   <= '0;
         cheat_q   <= 1'b0;
         retries_q <= 4'd0;
      end else begin
         state_q   <= state_n;
         level_q   <= level_n;
         a_q       <= a_n;
         cheat_q   <= cheat_n;
         retries_q <= retries_n;
         if (step)
            timer_q <= TW'(1);
         else if (timer_q != '1)
            timer_q <= timer_q + 1'b1;
      end
   end

   always_comb begin
      state_n   = state_q;
      level_n   = level_q;
      a_n       = a_q;
      cheat_n   = cheat_q;
      retries_n = retries_q;
      unique case (state_q)
         S_LAYLOW: begin
            if (bus.red) begin
               state_n = S_CHEAT;
               cheat_n = 1'b1;
            end else if (bus.green && timer_q >= LAY_TH) begin
               state_n = S_ATTACK;
               level_n = 4'd1;
               a_n     = a_q | A_ONE;
            end
         end
         S_ATTACK: begin
            if (bus.red) begin
               state_n = S_CHEAT;
               cheat_n = 1'b1;
            end else if (bus.yellow) begin
               // Retreat drops the flag earned by the level being left.
               a_n = a_q & ~(A_ONE << (level_q - 4'd1));
               if (level_q > 4'd1) begin
                  level_n = level_q - 4'd1;
               end else begin
                  state_n = S_LAYLOW;
                  level_n = 4'd0;
               end
            end else if (bus.green && timer_q >= ATK_TH) begin
               if (level_q < TOP) begin
                  level_n = level_q + 4'd1;
                  a_n     = a_q | (A_ONE << level_q);
               end else begin
                  state_n = S_CONNECT;
                  a_n     = a_q | (A_ONE << STAGES);
               end
            end
         end
         S_CHEAT: begin
            if (timer_q >= CHT_TH) begin
               if (bus.red) begin
                  state_n = S_FAIL;
               end else begin
                  state_n = S_LAYLOW;
                  level_n = 4'd0;
                  a_n     = '0;
                  cheat_n = 1'b0;
               end
            end
         end
         S_FAIL: begin
`ifdef SCP_079_RETRY_EN
            if (timer_q >= CHT_TH && !bus.red) begin
               state_n = S_LAYLOW;
               level_n = 4'd0;
               a_n     = '0;
               cheat_n = 1'b0;
               if (retries_q != 4'hF)
                  retries_n = retries_q + 4'd1;
            end
`else
            retries_n = 4'd0;
`endif
         end
         S_CONNECT: begin
            state_n = S_CONNECT;
         end
         default: begin
            state_n = S_LAYLOW;
         end
      endcase
   end

   always_comb begin
      bus.state     = state_q;
      bus.level     = level_q;
      bus.a         = a_q;
      bus.timer     = timer_q;
      bus.cheat_out = cheat_q;
      bus.retries   = retries_q;
   end

endmodule
